// File: rtl/cover_vector_packer_pkg.sv
// Field widths, vector layout and packing helper shared by the cover-vector writer.
package cover_vector_packer_pkg;

    localparam int unsigned OP_W      = 32;
    localparam int unsigned RM_W      = 8;
    localparam int unsigned FP_W      = 128;
    localparam int unsigned FMT_W     = 8;
    localparam int unsigned EXC_W     = 8;
    localparam int unsigned PAD_W     = 3;
    localparam int unsigned INTERMX_W = 32;
    localparam int unsigned INTERMM_W = 192;

    localparam int unsigned COVER_VECTOR_WIDTH = OP_W + RM_W + 4 * FP_W + 2 * FMT_W + EXC_W
                                               + PAD_W + 1 + INTERMX_W + INTERMM_W;
    localparam int unsigned NUM_WORDS = (COVER_VECTOR_WIDTH + 31) / 32;

    typedef enum logic [0:0] {StIdle, StSend} packer_state_e;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [RM_W-1:0]      rm;
        logic [FP_W-1:0]      a;
        logic [FP_W-1:0]      b;
        logic [FP_W-1:0]      c;
        logic [FMT_W-1:0]     operand_fmt;
        logic [FP_W-1:0]      result;
        logic [FMT_W-1:0]     result_fmt;
        logic [EXC_W-1:0]     exception_bits;
        logic [PAD_W-1:0]     pad;
        logic                 interm_s;
        logic [INTERMX_W-1:0] interm_x;
        logic [INTERMM_W-1:0] interm_m;
    } cover_vector_t;

    function automatic cover_vector_t pack_cover_vector(
        input logic [OP_W-1:0]      op,
        input logic [RM_W-1:0]      rm,
        input logic [FP_W-1:0]      a,
        input logic [FP_W-1:0]      b,
        input logic [FP_W-1:0]      c,
        input logic [FMT_W-1:0]     operand_fmt,
        input logic [FP_W-1:0]      result,
        input logic [FMT_W-1:0]     result_fmt,
        input logic [EXC_W-1:0]     exception_bits,
        input logic                 interm_s,
        input logic [INTERMX_W-1:0] interm_x,
        input logic [INTERMM_W-1:0] interm_m
    );
        cover_vector_t v;
        v.op             = op;
        v.rm             = rm;
        v.a              = a;
        v.b              = b;
        v.c              = c;
        v.operand_fmt    = operand_fmt;
        v.result         = result;
        v.result_fmt     = result_fmt;
        v.exception_bits = exception_bits;
        v.pad            = '0;
        v.interm_s       = interm_s;
        v.interm_x       = interm_x;
        v.interm_m       = interm_m;
        return v;
    endfunction

endpackage

// File: rtl/cover_vector_packer_fifo.sv
// DEPTH-entry synchronous FIFO of packed cover vectors; head is the oldest entry.
module cover_vector_packer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 804
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cover_vector_packer.sv
// Captures FP transactions, queues packed cover vectors and streams them MSW-first as words.
module cover_vector_packer
    import cover_vector_packer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      op,
    input  logic [RM_W-1:0]      rm,
    input  logic [FP_W-1:0]      a,
    input  logic [FP_W-1:0]      b,
    input  logic [FP_W-1:0]      c,
    input  logic [FMT_W-1:0]     operandFmt,
    input  logic [FP_W-1:0]      result,
    input  logic [FMT_W-1:0]     resultFmt,
    input  logic [EXC_W-1:0]     exceptionBits,
    input  logic                 intermS,
    input  logic [INTERMX_W-1:0] intermX,
    input  logic [INTERMM_W-1:0] intermM,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic                 out_last,
    output logic [31:0]          vec_count
);
    localparam int unsigned NUM_W    = (COVER_VECTOR_WIDTH + WORD_W - 1) / WORD_W;
    localparam int unsigned STREAM_W = NUM_W * WORD_W;
    localparam int unsigned IDX_W    = $clog2(NUM_W);
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_W - 1);

    packer_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       vec_count_q, vec_count_d;

    cover_vector_t     in_vec, head_vec;
    logic [STREAM_W-1:0] stream;
    logic [WORD_W-1:0] words [NUM_W];
    logic              push, pop, hs, full, empty;
    logic [CNT_W-1:0]  count;

    assign in_vec = pack_cover_vector(op, rm, a, b, c, operandFmt, result, resultFmt,
                                      exceptionBits, intermS, intermX, intermM);

    assign in_ready  = !full && !reset;
    assign push      = in_valid && in_ready;
    assign out_valid = (state_q == StSend);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && out_last;
    assign vec_count = vec_count_q;

    cover_vector_packer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COVER_VECTOR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_vec),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head_vec)
    );

    // Zero-extend on top so word 0 carries the pad bits above op.
    assign stream = STREAM_W'(head_vec);

    always_comb begin
        for (int i = 0; i < NUM_W; i++) begin
            words[i] = stream[(NUM_W-1-i)*WORD_W +: WORD_W];
        end
        out_data = out_valid ? words[idx_q] : '0;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_count_d = vec_count_q;
        unique case (state_q)
            StIdle: begin
                // A push into an empty FIFO is visible the very next cycle.
                if (!empty || push) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (hs) begin
                    if (out_last) begin
                        idx_d       = '0;
                        vec_count_d = vec_count_q + 32'd1;
                        if (!(count > CNT_W'(1) || push)) begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_count_q <= vec_count_d;
        end
    end

endmodule
